// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants and types for the instruction fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int unsigned      XLEN     = 32;
    localparam logic [XLEN-1:0]  RESET_PC = 32'h0000_2000;
    // Canonical RISC-V NOP (addi x0, x0, 0); driven on inst_data while idle
    localparam logic [31:0]      NOP_INST = 32'h0000_0013;

    // One slot of the in-flight / instruction queue
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            filled;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : In-order fetch queue. An entry is allocated when a request
//                is issued, filled when its response returns, and popped by
//                decode once filled. Pointers carry an extra wrap bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     alloc,
    input  logic [XLEN-1:0]          alloc_pc,
    input  logic                     fill,
    input  logic [31:0]              fill_data,
    input  logic                     pop,
    output logic                     inst_valid,
    output logic [31:0]              inst_data,
    output logic [XLEN-1:0]          inst_pc,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [$clog2(DEPTH):0]   outstanding
);
    import fetch_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W-1:0] fill_ptr_q,  fill_ptr_d;
    logic [PTR_W-1:0] head_ptr_q,  head_ptr_d;
    logic [DEPTH-1:0] filled_q,    filled_d;
    logic [XLEN-1:0]  pc_mem_q   [DEPTH];
    logic [XLEN-1:0]  pc_mem_d   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];
    logic [31:0]      inst_mem_d [DEPTH];

    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] fill_idx;
    logic [IDX_W-1:0] head_idx;

    assign alloc_idx   = alloc_ptr_q[IDX_W-1:0];
    assign fill_idx    = fill_ptr_q[IDX_W-1:0];
    assign head_idx    = head_ptr_q[IDX_W-1:0];

    // Wrap-bit pointer differences give allocated and not-yet-filled counts
    assign occupancy   = alloc_ptr_q - head_ptr_q;
    assign outstanding = alloc_ptr_q - fill_ptr_q;

    // A stale filled bit can linger in a freed slot, so gate on occupancy
    assign inst_valid  = (occupancy != '0) && filled_q[head_idx];
    assign inst_pc     = pc_mem_q[head_idx];
    assign inst_data   = inst_valid ? inst_mem_q[head_idx] : NOP_INST;

    // Next-state for pointers, filled flags and entry payloads
    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        filled_d    = filled_q;
        pc_mem_d    = pc_mem_q;
        inst_mem_d  = inst_mem_q;

        if (alloc) begin
            pc_mem_d[alloc_idx] = alloc_pc;
            filled_d[alloc_idx] = 1'b0;
            alloc_ptr_d         = alloc_ptr_q + PTR_W'(1);
        end
        if (fill) begin
            inst_mem_d[fill_idx] = fill_data;
            filled_d[fill_idx]   = 1'b1;
            fill_ptr_d           = fill_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            head_ptr_d = head_ptr_q + PTR_W'(1);
        end
        // A flush empties everything, overriding any same-cycle activity
        if (flush) begin
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
            filled_d    = '0;
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            filled_q    <= '0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            filled_q    <= filled_d;
        end
    end

    // Payload storage; contents are meaningless until the filled flag is set
    always_ff @(posedge clk) begin
        pc_mem_q   <= pc_mem_d;
        inst_mem_q <= inst_mem_d;
    end

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch front end. Issues sequential word fetches
//                to the icache, tracks in-flight requests in fetch_queue and
//                discards responses belonging to requests flushed by a
//                redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     icache_req_valid,
    input  logic                     icache_req_ready,
    output logic [XLEN-1:0]          icache_addr,
    input  logic                     icache_resp_valid,
    input  logic [31:0]              icache_resp_data,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [31:0]              inst_data,
    output logic [XLEN-1:0]          inst_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);
    import fetch_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  pc_q,       pc_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W:0]   inflight;
    logic             fire;
    logic             resp_accept;
    logic             pop;

    // Slots in use plus responses still owed from flushed requests must
    // never exceed the queue size, so a late response always has a home
    assign inflight         = {1'b0, occupancy} + {1'b0, drop_cnt_q};
    assign icache_req_valid = reset && !redirect_valid
                              && (inflight < (CNT_W+1)'(DEPTH));
    assign icache_addr      = pc_q;

    assign fire        = icache_req_valid && icache_req_ready;
    assign resp_accept = icache_resp_valid && (drop_cnt_q == '0)
                         && (outstanding != '0);
    assign pop         = inst_valid && inst_ready;

    fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .flush       (redirect_valid),
        .alloc       (fire),
        .alloc_pc    (pc_q),
        .fill        (resp_accept),
        .fill_data   (icache_resp_data),
        .pop         (pop),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .occupancy   (occupancy),
        .outstanding (outstanding)
    );

    // Fetch PC: redirect target (word aligned) wins, else step on each fire
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (fire) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    // Drop counter: flushed outstanding requests become responses to discard
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            // A response this cycle retires one owed response (either a
            // discard or a fill that the flush then throws away)
            if (icache_resp_valid && ((drop_cnt_q != '0) || (outstanding != '0))) begin
                drop_cnt_d = drop_cnt_q + outstanding - CNT_W'(1);
            end else begin
                drop_cnt_d = drop_cnt_q + outstanding;
            end
        end else if (icache_resp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
    end

    // Fetch PC and drop counter registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule : fetch_unit
`default_nettype wire
